inst_writer: RTL

INST_WRITER -- requirements
Module: inst_writer

---
 rtl/inst_writer_if.sv | 44 ++++
 rtl/inst_writer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/inst_writer_if.sv
// -----------------------------------------------------------------------------
// inst_writer_if
// Bundle of the session control, instruction-field input and memory-write
// output signals of inst_writer.
//   master : the side that drives start/stop/base_addr and the field bundle
//   slave  : inst_writer itself (drives in_ready and the memory-side outputs)
// Handshake: a bundle moves on a rising edge where in_valid && in_ready are
// both 1; the producer holds every field stable while in_valid is 1 and
// in_ready is 0, and in_ready never depends on in_valid.
// -----------------------------------------------------------------------------
interface inst_writer_if;
   logic        start;
   logic        stop;
   logic [31:0] base_addr;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  itype;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm;
   logic [31:0] address;
   logic [31:0] memIn;
   logic        write;
   logic        read;
   logic        err;
   logic [15:0] count;
   logic        full;

   modport master (
      output start, stop, base_addr, in_valid, itype, opcode, funct3, funct7,
             rd, rs1, rs2, imm,
      input  in_ready, address, memIn, write, read, err, count, full
   );

   modport slave (
      input  start, stop, base_addr, in_valid, itype, opcode, funct3, funct7,
             rd, rs1, rs2, imm,
      output in_ready, address, memIn, write, read, err, count, full
   );
endinterface

// File: rtl/inst_writer.sv
// -----------------------------------------------------------------------------
// inst_writer
// Encodes RISC-V style instruction field bundles (R/I/S/SB/UJ) into 32-bit
// words and writes them to consecutive word addresses of a memory, starting at
// a base address captured when a session opens. Illegal bundles are consumed
// and reported with a one-cycle err pulse.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        inst_writer_if.slave (session control, field bundle, memory side)
//   dbg_state  current FSM state (0=IDLE 1=READY 2=WRITE 3=FULL)
// -----------------------------------------------------------------------------
module inst_writer #(
   parameter int unsigned MAX_WORDS = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   inst_writer_if.slave  bus,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READY = 2'd1,
      WRITE = 2'd2,
      FULL  = 2'd3
   } state_t;

   localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

   state_t      state_q, state_d;
   logic [31:0] address_q;
   logic [31:0] mem_in_q;
   logic [15:0] count_q;
   logic        err_q;

   logic        accept;
   logic        legal;
   logic [31:0] enc;
   logic [16:0] count_inc;
   logic        imm_ok12, imm_ok13, imm_ok21;

   // stop closes the session this edge, so no bundle is taken alongside it
   assign bus.in_ready = (state_q == READY) && !bus.stop;
   assign accept       = bus.in_valid && bus.in_ready;
   assign count_inc    = {1'b0, count_q} + 17'd1;

   // Immediate range checks: the value fits in N signed bits when every bit
   // from N-1 upward equals the sign bit.
   assign imm_ok12 = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
   assign imm_ok13 = ((&bus.imm[31:12]) | ~(|bus.imm[31:12])) & ~bus.imm[0];
   assign imm_ok21 = ((&bus.imm[31:20]) | ~(|bus.imm[31:20])) & ~bus.imm[0];

   always_comb begin
      legal = 1'b0;
      enc   = 32'h0;
      case (bus.itype)
         3'd0: begin
            legal = (bus.opcode == 7'h33);
            enc   = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
         end
         3'd1: begin
            legal = ((bus.opcode == 7'h03) || (bus.opcode == 7'h13)) && imm_ok12;
            enc   = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
         end
         3'd2: begin
            legal = (bus.opcode == 7'h23) && imm_ok12;
            enc   = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0],
                     bus.opcode};
         end
         3'd3: begin
            legal = (bus.opcode == 7'h63) && imm_ok13;
            enc   = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                     bus.imm[4:1], bus.imm[11], bus.opcode};
         end
         3'd4: begin
            legal = (bus.opcode == 7'h6F) && imm_ok21;
            enc   = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                     bus.rd, bus.opcode};
         end
         default: begin
            legal = 1'b0;
            enc   = 32'h0;
         end
      endcase
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.start) state_d = READY;
         end
         READY: begin
            if (bus.stop)              state_d = IDLE;
            else if (accept && legal)  state_d = WRITE;
         end
         WRITE: begin
            // the write itself always completes; stop only picks the exit
            if (bus.stop)                  state_d = IDLE;
            else if (count_inc == MAX_W)   state_d = FULL;
            else                           state_d = READY;
         end
         FULL: begin
            if (bus.stop) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         address_q <= 32'h0;
         mem_in_q  <= 32'h0;
         count_q   <= 16'h0;
         err_q     <= 1'b0;
      end else begin
         err_q <= accept && !legal;
         if ((state_q == IDLE) && bus.start) begin
            address_q <= bus.base_addr;
            count_q   <= 16'h0;
         end
         if (accept && legal) mem_in_q <= enc;
         if (state_q == WRITE) begin
            address_q <= address_q + 32'd4;
            count_q   <= count_inc[15:0];
         end
      end
   end

   // write/full decode straight from state so reset drops them immediately
   assign bus.write   = (state_q == WRITE);
   assign bus.full    = (state_q == FULL);
   assign bus.read    = 1'b0;
   assign bus.err     = err_q;
   assign bus.address = address_q;
   assign bus.memIn   = mem_in_q;
   assign bus.count   = count_q;
   assign dbg_state   = state_q;

endmodule
